// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
//   Bundles every bus-level signal of the shared-ALU arbiter: the per-requester
//   request channel, the ALU pin-level drive/return, and the response channel.
//
//   Modports:
//     slave  - the arbiter side (consumes requests, drives ALU and response)
//     master - the environment side (requesters, ALU and response consumer)
//
//   Signals:
//     req_valid / req_ready          NUM_REQ   request handshake (ready one-hot)
//     req_operand_a / req_operand_b  NUM_REQ*32 packed operands, 32 bits each
//     req_alu_control                NUM_REQ*4  packed 4-bit ALU op codes
//     alu_operand_a/_b, alu_control  to the ALU
//     alu_result, alu_zero           from the ALU
//     rsp_valid / rsp_ready          response handshake
//     rsp_id, rsp_result, rsp_zero, rsp_error  response payload
//     busy                           arbiter has an operation in flight
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_operand_a;
    logic [NUM_REQ*32-1:0] req_operand_b;
    logic [NUM_REQ*4-1:0]  req_alu_control;

    logic [31:0]           alu_operand_a;
    logic [31:0]           alu_operand_b;
    logic [3:0]            alu_control;
    logic [31:0]           alu_result;
    logic                  alu_zero;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  rsp_zero;
    logic                  rsp_error;
    logic                  busy;

    modport slave (
        input  req_valid, req_operand_a, req_operand_b, req_alu_control,
        input  alu_result, alu_zero,
        input  rsp_ready,
        output req_ready,
        output alu_operand_a, alu_operand_b, alu_control,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_error,
        output busy
    );

    modport master (
        output req_valid, req_operand_a, req_operand_b, req_alu_control,
        output alu_result, alu_zero,
        output rsp_ready,
        input  req_ready,
        input  alu_operand_a, alu_operand_b, alu_control,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_error,
        input  busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational execute-stage ALU between NUM_REQ requesters
//   using round-robin arbitration. One operation is in flight at a time:
//     IDLE : pick a winner, latch its operands/op into the ALU drive registers
//     EXEC : ALU settles on the drive registers; capture result at the edge
//     RESP : hold the registered response until rsp_valid && rsp_ready
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    alu_share_arbiter_if.slave (request, ALU and response channels)
//
//   Parameters:
//     NUM_REQ  number of requesters, 2..4
//     ID_W     width of rsp_id, >= clog2(NUM_REQ)
//
//   Optional feature (macro ALU_OP_CHECK_EN):
//     When defined, ops with code > 9 are accepted but never reach the ALU;
//     the ALU sees op 0 with zero operands and the response carries
//     result 0, zero 1, error 1. When undefined, all ops are forwarded
//     unchanged and rsp_error is constant 0.
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_share_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Starting the pointer at the last requester makes requester 0 win first.
    localparam logic [ID_W-1:0] RR_RESET = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);

`ifdef ALU_OP_CHECK_EN
    // Codes 10..15 are not defined ALU operations.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op > 4'd9);
    endfunction
`endif

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [31:0]         alu_a_q, alu_a_d;
    logic [31:0]         alu_b_q, alu_b_d;
    logic [3:0]          alu_ctl_q, alu_ctl_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [31:0]         rsp_result_q, rsp_result_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic                busy_q, busy_d;
`ifdef ALU_OP_CHECK_EN
    logic                err_pend_q, err_pend_d;
    logic                rsp_error_q, rsp_error_d;
`endif

    logic [2*NUM_REQ-1:0] valid_dbl_s;
    logic [NUM_REQ-1:0]   valid_rot_s;
    logic [ID_W:0]        search_base_s;
    logic [ID_W:0]        grant_off_s;
    logic [ID_W:0]        winner_sum_s;
    logic                 grant_found_s;
    logic [ID_W-1:0]      grant_idx_s;
    logic [NUM_REQ-1:0]   grant_onehot_s;
    logic [31:0]          sel_a_s;
    logic [31:0]          sel_b_s;
    logic [3:0]           sel_ctl_s;

    // Round-robin search: rotate valids so the slot after rr_ptr sits at bit 0,
    // take the lowest set bit, then map the offset back to a requester index.
    always_comb begin
        valid_dbl_s   = {bus.req_valid, bus.req_valid};
        search_base_s = {1'b0, rr_ptr_q} + (ID_W+1)'(1);
        valid_rot_s   = NUM_REQ'(valid_dbl_s >> search_base_s);
        grant_found_s = |valid_rot_s;
        grant_off_s   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            grant_off_s = valid_rot_s[i] ? (ID_W+1)'(i) : grant_off_s;
        end
        // base <= NUM_REQ and offset <= NUM_REQ-1, so one wrap step suffices.
        winner_sum_s = search_base_s + grant_off_s;
        if (winner_sum_s >= NUM_REQ_W) begin
            grant_idx_s = ID_W'(winner_sum_s - NUM_REQ_W);
        end else begin
            grant_idx_s = ID_W'(winner_sum_s);
        end
    end

    // One-hot grant vector and payload mux of the winning requester.
    always_comb begin
        grant_onehot_s = '0;
        sel_a_s        = 32'h0000_0000;
        sel_b_s        = 32'h0000_0000;
        sel_ctl_s      = 4'h0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_onehot_s[i] = grant_found_s && (grant_idx_s == ID_W'(i));
            sel_a_s   = sel_a_s   | ({32{grant_onehot_s[i]}} & bus.req_operand_a[32*i +: 32]);
            sel_b_s   = sel_b_s   | ({32{grant_onehot_s[i]}} & bus.req_operand_b[32*i +: 32]);
            sel_ctl_s = sel_ctl_s | ({4{grant_onehot_s[i]}}  & bus.req_alu_control[4*i +: 4]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: accept is combinational and only offered while idle.
    always_comb begin
        if (state_q == ST_IDLE) begin
            bus.req_ready = grant_onehot_s;
        end else begin
            bus.req_ready = '0;
        end
    end

    // Datapath next-state: latch on grant, capture ALU on EXEC, drop on handshake.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctl_d    = alu_ctl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
`ifdef ALU_OP_CHECK_EN
        err_pend_d   = err_pend_q;
        rsp_error_d  = rsp_error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    rr_ptr_d = grant_idx_s;
                    id_d     = grant_idx_s;
`ifdef ALU_OP_CHECK_EN
                    if (is_illegal_op(sel_ctl_s)) begin
                        alu_a_d    = 32'h0000_0000;
                        alu_b_d    = 32'h0000_0000;
                        alu_ctl_d  = 4'h0;
                        err_pend_d = 1'b1;
                    end else begin
                        alu_a_d    = sel_a_s;
                        alu_b_d    = sel_b_s;
                        alu_ctl_d  = sel_ctl_s;
                        err_pend_d = 1'b0;
                    end
`else
                    alu_a_d   = sel_a_s;
                    alu_b_d   = sel_b_s;
                    alu_ctl_d = sel_ctl_s;
`endif
                end else begin
                    // Drive registers keep their last values to limit toggling.
                    rr_ptr_d = rr_ptr_q;
                end
            end
            ST_EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
`ifdef ALU_OP_CHECK_EN
                if (err_pend_q) begin
                    rsp_result_d = 32'h0000_0000;
                    rsp_zero_d   = 1'b1;
                    rsp_error_d  = 1'b1;
                end else begin
                    rsp_result_d = bus.alu_result;
                    rsp_zero_d   = bus.alu_zero;
                    rsp_error_d  = 1'b0;
                end
`else
                rsp_result_d = bus.alu_result;
                rsp_zero_d   = bus.alu_zero;
`endif
            end
            ST_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end else begin
                    rsp_valid_d = rsp_valid_q;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Busy is registered and mirrors the state being EXEC or RESP.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
    end

    // Datapath and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= RR_RESET;
            id_q         <= '0;
            alu_a_q      <= 32'h0000_0000;
            alu_b_q      <= 32'h0000_0000;
            alu_ctl_q    <= 4'h0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= 32'h0000_0000;
            rsp_zero_q   <= 1'b0;
            busy_q       <= 1'b0;
`ifdef ALU_OP_CHECK_EN
            err_pend_q   <= 1'b0;
            rsp_error_q  <= 1'b0;
`endif
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctl_q    <= alu_ctl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            busy_q       <= busy_d;
`ifdef ALU_OP_CHECK_EN
            err_pend_q   <= err_pend_d;
            rsp_error_q  <= rsp_error_d;
`endif
        end
    end

    assign bus.alu_operand_a = alu_a_q;
    assign bus.alu_operand_b = alu_b_q;
    assign bus.alu_control   = alu_ctl_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_result    = rsp_result_q;
    assign bus.rsp_zero      = rsp_zero_q;
    assign bus.busy          = busy_q;
`ifdef ALU_OP_CHECK_EN
    assign bus.rsp_error     = rsp_error_q;
`else
    assign bus.rsp_error     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Directed self-checking bench for alu_share_arbiter (NUM_REQ=2, ID_W=2).
//   A behavioural ALU closes the loop on the ALU pins; every expected value
//   below is a hand-computed constant.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_share_arbiter;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    alu_share_arbiter_if #(.NUM_REQ(2), .ID_W(2)) bus ();

    alu_share_arbiter #(.NUM_REQ(2), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU; illegal codes return 0 with zero=1.
    logic [31:0] alu_res_s;
    always_comb begin
        alu_res_s = 32'h0000_0000;
        case (bus.alu_control)
            4'd0: alu_res_s = bus.alu_operand_a + bus.alu_operand_b;
            4'd1: alu_res_s = bus.alu_operand_a - bus.alu_operand_b;
            4'd2: alu_res_s = bus.alu_operand_a & bus.alu_operand_b;
            4'd3: alu_res_s = bus.alu_operand_a | bus.alu_operand_b;
            4'd4: alu_res_s = bus.alu_operand_a ^ bus.alu_operand_b;
            4'd5: alu_res_s = {31'd0, $signed(bus.alu_operand_a) < $signed(bus.alu_operand_b)};
            4'd6: alu_res_s = {31'd0, bus.alu_operand_a < bus.alu_operand_b};
            4'd7: alu_res_s = bus.alu_operand_a << bus.alu_operand_b[4:0];
            4'd8: alu_res_s = bus.alu_operand_a >> bus.alu_operand_b[4:0];
            4'd9: alu_res_s = $unsigned($signed(bus.alu_operand_a) >>> bus.alu_operand_b[4:0]);
            default: alu_res_s = 32'h0000_0000;
        endcase
        bus.alu_result = alu_res_s;
        bus.alu_zero   = (alu_res_s == 32'h0000_0000);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op);
        bus.req_valid[i]                = v;
        bus.req_operand_a[32*i +: 32]   = a;
        bus.req_operand_b[32*i +: 32]   = b;
        bus.req_alu_control[4*i +: 4]   = op;
    endtask

    initial begin
        pass_cnt            = 0;
        total_cnt           = 0;
        rst_n               = 1'b0;
        bus.req_valid       = '0;
        bus.req_operand_a   = '0;
        bus.req_operand_b   = '0;
        bus.req_alu_control = '0;
        bus.rsp_ready       = 1'b0;

        // ---- reset state ----
        #3;
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_busy",      {31'd0, bus.busy},      32'd0);
        check("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
        check("rst_rsp_result", bus.rsp_result,        32'd0);
        check("rst_rsp_id",    {30'd0, bus.rsp_id},    32'd0);
        check("rst_alu_a",     bus.alu_operand_a,      32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // ---- ADD 5+7 from requester 0 ----
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'd5, 32'd7, 4'd0);
        #1;
        check("add_req_ready", {30'd0, bus.req_ready}, 32'd1);
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("add_exec_busy",  {31'd0, bus.busy},      32'd1);
        check("add_exec_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("add_exec_alu_a", bus.alu_operand_a,      32'd5);
        check("add_exec_ready", {30'd0, bus.req_ready}, 32'd0);
        tick();
        check("add_rsp_valid",  {31'd0, bus.rsp_valid}, 32'd1);
        check("add_rsp_result", bus.rsp_result,         32'd12);
        check("add_rsp_zero",   {31'd0, bus.rsp_zero},  32'd0);
        check("add_rsp_id",     {30'd0, bus.rsp_id},    32'd0);
        tick();
        check("add_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("add_idle_busy",  {31'd0, bus.busy},      32'd0);

        // ---- reset pulse, then two continuous SUB 3-3 requesters ----
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        set_req(0, 1'b1, 32'd3, 32'd3, 4'd1);
        set_req(1, 1'b1, 32'd3, 32'd3, 4'd1);
        #1;
        for (int j = 0; j < 4; j++) begin
            check("rr_grant", {30'd0, bus.req_ready}, (j % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            tick();
            check("rr_valid",  {31'd0, bus.rsp_valid}, 32'd1);
            check("rr_result", bus.rsp_result,         32'd0);
            check("rr_zero",   {31'd0, bus.rsp_zero},  32'd1);
            check("rr_id",     {30'd0, bus.rsp_id},    (j % 2 == 0) ? 32'd0 : 32'd1);
            tick();
        end
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);

        // ---- SRA with response back-pressure for 5 cycles ----
        bus.rsp_ready = 1'b0;
        set_req(1, 1'b1, 32'h8000_0000, 32'd4, 4'd9);
        #1;
        check("sra_grant", {30'd0, bus.req_ready}, 32'd2);
        tick();
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd5);
        tick();
        for (int j = 0; j < 5; j++) begin
            check("sra_result", bus.rsp_result,         32'hF800_0000);
            check("sra_valid",  {31'd0, bus.rsp_valid}, 32'd1);
            check("sra_busy",   {31'd0, bus.busy},      32'd1);
            check("sra_ready",  {30'd0, bus.req_ready}, 32'd0);
            check("sra_id",     {30'd0, bus.rsp_id},    32'd1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("sra_release_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("sra_release_busy",  {31'd0, bus.busy},      32'd0);
        check("sra_release_hold",  bus.rsp_result,         32'hF800_0000);

        // ---- SLT -1 < 1 from requester 0 ----
        check("slt_grant", {30'd0, bus.req_ready}, 32'd1);
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        check("slt_result", bus.rsp_result,      32'd1);
        check("slt_id",     {30'd0, bus.rsp_id}, 32'd0);
        tick();

        // ---- SLTU 0xFFFFFFFF < 1 from lone requester 1 ----
        set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd6);
        #1;
        check("sltu_grant", {30'd0, bus.req_ready}, 32'd2);
        tick();
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        check("sltu_result", bus.rsp_result,        32'd0);
        check("sltu_zero",   {31'd0, bus.rsp_zero}, 32'd1);
        check("sltu_id",     {30'd0, bus.rsp_id},   32'd1);
        tick();

        // ---- reset asserted while in RESP ----
        bus.rsp_ready = 1'b0;
        set_req(1, 1'b1, 32'd1, 32'd1, 4'd0);
        #1;
        tick();
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        check("mid_rst_pre_valid", {31'd0, bus.rsp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("mid_rst_busy",  {31'd0, bus.busy},      32'd0);
        #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 4'd4);
        set_req(1, 1'b1, 32'd9, 32'd9, 4'd0);
        #1;
        check("post_rst_grant", {30'd0, bus.req_ready}, 32'd1);
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        check("post_rst_result", bus.rsp_result,      32'h0000_0FF0);
        check("post_rst_id",     {30'd0, bus.rsp_id}, 32'd0);
        tick();

        // ---- illegal op code 12 from requester 0 ----
        set_req(0, 1'b1, 32'd123, 32'd456, 4'b1100);
        #1;
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
`ifdef ALU_OP_CHECK_EN
        check("ill_alu_ctl", {28'd0, bus.alu_control}, 32'd0);
        check("ill_alu_a",   bus.alu_operand_a,        32'd0);
`else
        check("ill_alu_ctl", {28'd0, bus.alu_control}, 32'd12);
        check("ill_alu_a",   bus.alu_operand_a,        32'd123);
`endif
        tick();
        check("ill_valid",  {31'd0, bus.rsp_valid}, 32'd1);
        check("ill_result", bus.rsp_result,         32'd0);
        check("ill_zero",   {31'd0, bus.rsp_zero},  32'd1);
`ifdef ALU_OP_CHECK_EN
        check("ill_error",  {31'd0, bus.rsp_error}, 32'd1);
`else
        check("ill_error",  {31'd0, bus.rsp_error}, 32'd0);
`endif
        tick();
        check("ill_done_valid", {31'd0, bus.rsp_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one execute-stage `alu` instance between up to NUM_REQ requesters, e.g. the integer pipe, branch compare and address generation.
- Arbitration is round-robin. Each accepted operation is registered into the ALU and the registered result is returned with a valid/ready handshake.
- Sits in Execute, between the requesters and the ALU's operand_a/operand_b/alu_control/result/zero pins.
- Processes one operation at a time.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..4.
- ID_W, 2: width of rsp_id; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept; high only for the granted requester, only in IDLE.
- req_operand_a  in  NUM_REQ*32  packed; requester i uses bits [32i+31:32i].
- req_operand_b  in  NUM_REQ*32  packed, same layout.
- req_alu_control  in  NUM_REQ*4  packed 4-bit ALU op, bits [4i+3:4i].
- alu_operand_a  out  32  to ALU operand_a.
- alu_operand_b  out  32  to ALU operand_b.
- alu_control  out  4  to ALU alu_control.
- alu_result  in  32  from ALU result.
- alu_zero  in  1  from ALU zero.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  32  registered ALU result.
- rsp_zero  out  1  registered zero flag.
- rsp_error  out  1  illegal op flag; see Optional Feature.
- busy  out  1  high in EXEC or RESP.

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous, active-low, and deasserts synchronously externally.
- ALU op encoding (4 bits):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
  - 10-15 are illegal. The ALU returns 0 with zero=1 for these.
- Reset values:
  - FSM state = IDLE.
  - rr_ptr = NUM_REQ-1, so requester 0 has top priority first.
  - All ALU drive registers = 0.
  - rsp_valid, rsp_result, rsp_zero, rsp_error, rsp_id, busy = 0.
  - req_ready = 0.
- FSM states:
  - IDLE: req_ready is combinational. The grant goes to the first requester with req_valid set, searching upward from (rr_ptr+1) mod NUM_REQ. At the edge, the winner's operands/op are latched into the ALU drive registers, its index into id_q, and rr_ptr <= winner; next state EXEC. No valid requests: stay in IDLE, all req_ready=0.
  - EXEC: alu_* outputs come from the drive registers; the ALU path is combinational and must settle within this cycle. At the edge: rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_id<=id_q, rsp_valid<=1; next state RESP.
  - RESP: rsp_* are held stable. When rsp_valid&&rsp_ready at an edge: rsp_valid<=0, next state IDLE. Otherwise remain in RESP.
- Latency and throughput:
  - A request accepted at edge k gives rsp_valid high after edge k+1.
  - With rsp_ready tied high, an op takes 3 cycles. The next accept is at edge k+3 at the earliest.
- Handshake rules:
  - A requester must hold valid and payload stable until its req_ready is seen.
  - Requests that are not granted are unaffected.
  - Deasserting req_valid before grant is legal.
- Round-robin fairness: under continuous requests from all requesters, each is granted exactly once per NUM_REQ grants.
- ALU drive registers hold their last values outside EXEC; they are not cleared, to limit toggling.
- Boundaries:
  - Lone requester: granted every round, whatever rr_ptr is.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Reset in EXEC or RESP: the in-flight op is discarded, no response is produced, and state returns to IDLE immediately.
  - rsp_ready high in IDLE or EXEC: ignored.

Optional Feature:
- Macro: ALU_OP_CHECK_EN.
- Defined: in IDLE, a granted op with alu_control > 9 is accepted normally. It is not presented to the ALU: alu_control is driven as 0 with operands 0. The response has rsp_result=0, rsp_zero=1, rsp_error=1. Timing is unchanged.
- Undefined: the op is forwarded to the ALU unchanged and rsp_error is tied 0.

Test Plan:
- Reset, then req0 ADD a=5 b=7, rsp_ready=1 -> req_ready[0] at edge 0; rsp_valid after edge 1 with rsp_result=12, rsp_zero=0, rsp_id=0; idle by edge 2.
- req0 and req1 both held valid with SUB 3-3, continuously -> grant order 0,1,0,1; every response has result 0, zero=1, and ids alternate.
- req1 SRA a=0x80000000 b=4 with rsp_ready=0 for 5 cycles -> rsp_result=0xF8000000 stable throughout, busy=1, req_ready=0 throughout; released one edge after rsp_ready=1.
- SLT a=0xFFFFFFFF b=1 -> 1; SLTU with same operands -> 0.
- rst_n pulsed low during RESP -> rsp_valid=0 and busy=0 asynchronously; next request gets id 0 priority.
- req0 op 4'b1100 -> with ALU_OP_CHECK_EN: rsp_error=1, result=0, zero=1. Without: rsp_error=0, result=0.
